// File: rtl/crossbar_nxn_rr.sv
// N x N registered crossbar: every output has a round-robin arbiter feeding a
// one-deep valid/ready output register, so any permutation routes in one cycle.
`timescale 1ns / 1ps

module crossbar_nxn_rr #(
    parameter int N = 4,
    parameter int W = 4,
    localparam int DW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    in_valid,
    input  logic [N*DW-1:0] in_dest,
    input  logic [N*W-1:0]  in_data,
    output logic [N-1:0]    in_ready,
    output logic [N-1:0]    out_valid,
    output logic [N*W-1:0]  out_data,
    output logic [N*DW-1:0] out_src,
    input  logic [N-1:0]    out_ready
);

    logic [DW-1:0] dest    [N];
    logic [W-1:0]  data    [N];
    logic [N-1:0]  req     [N];   // req[j][i]: input i wants output j
    logic [N-1:0]  free;
    logic [N-1:0]  gnt_any;
    logic [DW-1:0] gnt_idx [N];

    logic [N-1:0]  o_valid;
    logic [W-1:0]  o_data  [N];
    logic [DW-1:0] o_src   [N];
    logic [DW-1:0] ptr     [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            dest[i] = in_dest[i*DW +: DW];
            data[i] = in_data[i*W +: W];
        end
    end

    always_comb begin
        for (int j = 0; j < N; j++) begin
            for (int i = 0; i < N; i++) begin
                req[j][i] = in_valid[i] && (dest[i] == DW'(j));
            end
        end
    end

    // A held word frees its slot in the same cycle the consumer takes it.
    assign free = ~o_valid | out_ready;

    // Cyclic scan from ptr[j]; N is a power of two, so the DW-bit add wraps.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            logic          hit;
            logic [DW-1:0] idx;
            // NOTE: every combinational output gets a default before any
            // conditional write, so no path leaves it unassigned (no latch).
            hit        = 1'b0;
            gnt_idx[j] = '0;
            for (int k = 0; k < N; k++) begin
                idx = ptr[j] + DW'(k);
                if (!hit && req[j][idx]) begin
                    hit        = 1'b1;
                    gnt_idx[j] = idx;
                end
            end
            gnt_any[j] = hit && free[j];
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = rst_n && in_valid[i] && gnt_any[dest[i]]
                          && (gnt_idx[dest[i]] == DW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the output registers are few and externally visible, so
            // each is cleared by reset rather than left undefined.
            for (int j = 0; j < N; j++) begin
                o_valid[j] <= 1'b0;
                o_data[j]  <= '0;
                o_src[j]   <= '0;
                ptr[j]     <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every output samples the
            // pre-edge state regardless of loop order.
            for (int j = 0; j < N; j++) begin
                if (gnt_any[j]) begin
                    o_valid[j] <= 1'b1;
                    o_data[j]  <= data[gnt_idx[j]];
                    o_src[j]   <= gnt_idx[j];
                    ptr[j]     <= gnt_idx[j] + DW'(1);
                end else begin
                    o_valid[j] <= o_valid[j] && !out_ready[j];
                end
            end
        end
    end

    assign out_valid = o_valid;

    always_comb begin
        out_data = '0;
        out_src  = '0;
        for (int j = 0; j < N; j++) begin
            out_data[j*W +: W]   = o_data[j];
            out_src[j*DW +: DW]  = o_src[j];
        end
    end

endmodule
